mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single 8-bit-wide unified memory port between the instruction fetcher (cache-line refills) and the load/store unit (byte/half/word loads and stores). It serialises each request into byte transfers, pipelines reads against the one-cycle memory latency, and returns a one-cycle completion pulse. It also stalls stores to the I/O region while the I/O buffer is full, and drops in-flight instruction refills on a ROB flush.

## Interface
- LINE_BYTES, 16: cache-line size in bytes; power of 2, ≥4.
- ADDR_WIDTH, 32: memory address width.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global enable; low freezes every register.
- if_valid  in  1  fetcher requests a line refill.
- if_addr  in  ADDR_WIDTH  refill address; low log2(LINE_BYTES) bits ignored (forced 0).
- if_ready  out  1  one-cycle pulse: if_line valid.
- if_line  out  8*LINE_BYTES  line data; byte i at bits [8i+7:8i].
- flush  in  1  ROB reset; aborts instruction refills only.
- ls_valid  in  1  LSU request.
- ls_addr  in  ADDR_WIDTH  byte address.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- ls_wdata  in  32  store data, little-endian.
- ls_ready  out  1  one-cycle pulse: load data valid or store complete.
- ls_rdata  out  32  load data, little-endian, zero-extended.
- mem_din  in  8  memory read data.
- mem_dout  out  8  memory write data.
- mem_a  out  ADDR_WIDTH  memory address.
- mem_wr  out  1  1 = write this cycle.
- io_buffer_full  in  1  I/O write buffer full.

## Operation
- States: IDLE, IFETCH, LOAD, STORE, DONE. A 2-bit or 3-bit encoding is acceptable.
- Reset (rst=0 at edge):
  - state=IDLE; all outputs 0; counters 0.
  - last_grant=LSU.
- IDLE arbitration, sampled at the edge:
  - Only one valid requester: grant it.
  - Both valid: grant the one not equal to last_grant.
  - If flush is high, if_valid is ignored.
  - Grant latches the address, size (N = LINE_BYTES for IFETCH, 1/2/4 for LSU), we and wdata, and updates last_grant.
- Byte order: byte k uses address base+k, k = 0..N-1, ascending.
- Read (IFETCH/LOAD): pipelined.
  - Issue counter issues one address per cycle with mem_wr=0.
  - Receive counter captures mem_din into byte slot k at the end of the cycle after address k was presented.
  - After byte N-1 is captured, go to DONE.
- Store (STORE): each cycle drives mem_a=base+k, mem_dout=wdata byte k, mem_wr=1, and increments k.
  - I/O stall: if base[17:16]==2'b11 and io_buffer_full=1, the cycle is a stall with mem_wr=0 and k held.
  - After byte N-1 is written, go to DONE.
- DONE (one cycle):
  - Exactly one of if_ready/ls_ready is 1; the data outputs hold the result.
  - Requests are not sampled, because requesters drop valid on the edge that ends this cycle.
  - Next state is IDLE.
- flush during IFETCH: the next state is IDLE, the partial line is discarded, and no if_ready pulse is produced.
- flush during LOAD/STORE/DONE(LSU): ignored; the operation completes.
- flush during DONE(IFETCH): if_ready is still pulsed; the fetcher discards it by address compare.
- if_line and ls_rdata hold their last values outside DONE; there is no need to clear them.
- mem_a/mem_dout are don't-care while mem_wr=0 outside transfers; they must not toggle mem_wr.

## Timing
- rdy=0: no register updates and mem_wr is gated to 0. Memory stalls with rdy, so the read pipeline resumes intact.
- Read of N bytes, with the request sampled at edge t0:
  - mem_a=base+k during cycle t0+1+k.
  - Byte k is captured at the end of cycle t0+2+k.
  - The ready pulse is in cycle t0+N+2.
  - Resulting latencies: word load = 6 cycles from the request edge; 16-byte line = 18 cycles.
- Store of N bytes without stall: writes in cycles t0+1 .. t0+N; ls_ready in cycle t0+N+1. Each stall cycle adds 1.
- Minimum gap: a new grant is possible at the edge ending the cycle after DONE. Back-to-back transfers are separated by the IDLE cycle.
- Reset mid-operation: returns to IDLE immediately and mem_wr=0 in the following cycle; no ready pulse.

## Test plan
- Refill: memory holds byte value = addr[7:0]; if_valid, if_addr=0x1004 -> mem_a sweeps 0x1000..0x100F; if_ready is 1 in cycle t0+18; if_line = 0x0F0E…0100.
- Word load then half store: ls_addr=0x20, load, memory 0x20..0x23 = 11 22 33 44 -> ls_rdata=0x44332211 at t0+6. Then a store with size=1, wdata=0xBEEF to 0x40 -> writes EF to 0x40 and BE to 0x41; ls_ready at t0+3.
- Contention: if_valid and ls_valid both asserted after reset -> IFETCH is granted first, then LSU, then IFETCH again on repeated ties.
- Flush: flush pulses 5 cycles into a refill -> IDLE on the next cycle, no if_ready, a new if_valid is served from byte 0.
- I/O stall: store byte 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 for 3 cycles, then one write; ls_ready is delayed by 3.
- rdy/reset: rdy low for 4 cycles mid-load -> same data with latency +4. rst low mid-store -> mem_wr=0 next cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response and byte-wide memory bus of the unified memory arbiter.
// The arbiter takes the slave side; fetcher, LSU and memory sit on the master side.
interface mem_arbiter_if #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    if_valid;
  logic [ADDR_WIDTH-1:0]   if_addr;
  logic                    if_ready;
  logic [8*LINE_BYTES-1:0] if_line;
  logic                    flush;
  logic                    ls_valid;
  logic [ADDR_WIDTH-1:0]   ls_addr;
  logic                    ls_we;
  logic [1:0]              ls_size;
  logic [31:0]             ls_wdata;
  logic                    ls_ready;
  logic [31:0]             ls_rdata;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [ADDR_WIDTH-1:0]   mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  modport slave (
    input  if_valid, if_addr, flush, ls_valid, ls_addr, ls_we, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    output if_ready, if_line, ls_ready, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_valid, if_addr, flush, ls_valid, ls_addr, ls_we, ls_size, ls_wdata,
           mem_din, io_buffer_full,
    input  if_ready, if_line, ls_ready, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the 8-bit memory port between line refills and LSU accesses,
// serialising each request into ascending byte transfers with a pipelined read path.
module mem_arbiter #(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(LINE_BYTES) + 1;

  typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] base;
    logic [CW-1:0]         n;
    logic [31:0]           wdata;
  } req_t;

  state_t                      state;
  req_t                        req;
  logic                        last_ls;
  logic [CW-1:0]               ptr;
  logic [CW-1:0]               rcnt;
  logic                        rd_vld;
  logic [LINE_BYTES-1:0][7:0]  line_buf;
  logic [LINE_BYTES-1:0][7:0]  line_nxt;
  logic                        if_ready_q;
  logic                        ls_ready_q;
  logic [8*LINE_BYTES-1:0]     if_line_q;
  logic [31:0]                 ls_rdata_q;
  logic [31:0]                 ls_rdata_nxt;

  logic if_req, grant_if, grant_ls, io_stall, last_rd;

  function automatic logic [CW-1:0] ls_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return CW'(1);
      2'd1:    return CW'(2);
      default: return CW'(4);
    endcase
  endfunction

  // Ties go to whichever requester was not served last.
  assign if_req   = bus.if_valid & ~bus.flush;
  assign grant_if = if_req & (~bus.ls_valid | last_ls);
  assign grant_ls = bus.ls_valid & ~grant_if;

  assign io_stall = (req.base[17:16] == 2'b11) & bus.io_buffer_full;
  assign last_rd  = rd_vld & (rcnt == req.n - 1'b1);

  // Byte lanes of the line buffer: lane rcnt takes the data returned for the
  // address presented one cycle earlier.
  for (genvar i = 0; i < LINE_BYTES; i++) begin : g_lane
    assign line_nxt[i] = (rd_vld && rcnt == CW'(i)) ? bus.mem_din : line_buf[i];
  end

  always_comb begin
    ls_rdata_nxt = '0;
    for (int b = 0; b < 4; b++)
      if (CW'(b) < req.n) ls_rdata_nxt[8*b +: 8] = line_nxt[b];
  end

  assign bus.mem_a    = req.base + ADDR_WIDTH'(ptr);
  assign bus.mem_dout = req.wdata[{ptr[1:0], 3'b000} +: 8];
  assign bus.mem_wr   = rdy & (state == STORE) & ~io_stall;
  assign bus.if_ready = if_ready_q;
  assign bus.ls_ready = ls_ready_q;
  assign bus.if_line  = if_line_q;
  assign bus.ls_rdata = ls_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      req        <= '0;
      last_ls    <= 1'b1;
      ptr        <= '0;
      rcnt       <= '0;
      rd_vld     <= 1'b0;
      line_buf   <= '0;
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      if_line_q  <= '0;
      ls_rdata_q <= '0;
    end else if (rdy) begin
      if_ready_q <= 1'b0;
      ls_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          ptr    <= '0;
          rcnt   <= '0;
          rd_vld <= 1'b0;
          if (grant_if) begin
            req.base <= bus.if_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
            req.n    <= CW'(LINE_BYTES);
            last_ls  <= 1'b0;
            state    <= IFETCH;
          end else if (grant_ls) begin
            req.base  <= bus.ls_addr;
            req.n     <= ls_bytes(bus.ls_size);
            req.wdata <= bus.ls_wdata;
            last_ls   <= 1'b1;
            state     <= bus.ls_we ? STORE : LOAD;
          end
        end
        IFETCH, LOAD: begin
          if (state == IFETCH && bus.flush) begin
            state <= IDLE;
          end else begin
            // Issue side runs one address ahead of the capture side.
            rd_vld <= 1'b1;
            if (ptr != req.n - 1'b1) ptr <= ptr + 1'b1;
            if (rd_vld) begin
              line_buf <= line_nxt;
              rcnt     <= rcnt + 1'b1;
            end
            if (last_rd) begin
              state <= DONE;
              if (state == IFETCH) begin
                if_ready_q <= 1'b1;
                if_line_q  <= line_nxt;
              end else begin
                ls_ready_q <= 1'b1;
                ls_rdata_q <= ls_rdata_nxt;
              end
            end
          end
        end
        STORE: begin
          if (!io_stall) begin
            if (ptr == req.n - 1'b1) begin
              state      <= DONE;
              ls_ready_q <= 1'b1;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a byte-array memory model predicts every
// response and every write; a negedge monitor compares what the DUT presents.
module tb_mem_arbiter;
  localparam int LB = 16;
  localparam int AW = 32;

  typedef struct {
    bit           is_ls;
    bit           chk;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic load_mem = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t sb[$];
  wr_t  wq[$];
  exp_t me;
  wr_t  mw;

  logic [7:0] mem     [0:262143];
  logic [7:0] ref_mem [0:262143];

  mem_arbiter_if #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) bus();

  mem_arbiter #(.LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle-latency byte memory; it stalls together with rdy.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 262144; i++) mem[i] <= ref_mem[i];
    end else if (rdy) begin
      if (bus.mem_wr) mem[bus.mem_a[17:0]] <= bus.mem_dout;
      bus.mem_din <= mem[bus.mem_a[17:0]];
    end
  end

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.if_ready || bus.ls_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: if_ready=%0b ls_ready=%0b at cycle %0d, required no pulse",
                 bus.if_ready, bus.ls_ready, cyc);
      end else begin
        me = sb.pop_front();
        check("ready_kind", 128'({bus.ls_ready, bus.if_ready}), me.is_ls ? 128'd2 : 128'd1);
        if (me.cyc >= 0) check("ready_cycle", 128'(cyc), 128'(me.cyc));
        if (me.chk) begin
          if (me.is_ls) check("ls_rdata", 128'(bus.ls_rdata), me.data);
          else          check("if_line", bus.if_line, me.data);
        end
      end
    end
    if (bus.mem_wr === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: mem_a=%h mem_dout=%h, required no write", bus.mem_a, bus.mem_dout);
      end else begin
        mw = wq.pop_front();
        check("wr_addr", 128'(bus.mem_a), 128'(mw.a));
        check("wr_data", 128'(bus.mem_dout), 128'(mw.d));
      end
    end
  end

  function automatic logic [127:0] model_read(input logic [31:0] base, input int n);
    logic [127:0] d;
    logic [31:0]  a;
    d = '0;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k);
      d[8*k +: 8] = ref_mem[a[17:0]];
    end
    return d;
  endfunction

  function automatic void model_store(input logic [31:0] base, input int n, input logic [31:0] wd);
    wr_t w;
    for (int k = 0; k < n; k++) begin
      w.a = base + 32'(k);
      w.d = wd[8*k +: 8];
      wq.push_back(w);
      ref_mem[w.a[17:0]] = w.d;
    end
  endfunction

  task automatic wait_done();
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: %0d response(s) outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One request from an idle arbiter; stalls = cycles io_buffer_full stays high,
  // rgap = cycles rdy is held low starting two cycles after the grant.
  task automatic do_req(input bit is_if, input logic [31:0] addr, input bit we,
                        input logic [1:0] size, input logic [31:0] wdata,
                        input int stalls, input int rgap, input bit fl);
    int          n, lat, t0;
    logic [31:0] base;
    exp_t        e;
    base    = is_if ? (addr & ~32'(LB - 1)) : addr;
    n       = is_if ? LB : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e.is_ls = !is_if;
    e.chk   = is_if || !we;
    e.data  = '0;
    if (!is_if && we) begin
      model_store(base, n, wdata);
      lat = n + ((base[17:16] == 2'b11) ? stalls : 0);
    end else begin
      e.data = model_read(base, n);
      lat    = n + 1;
    end
    lat += rgap;
    if (is_if) begin
      bus.if_valid = 1'b1;
      bus.if_addr  = addr;
    end else begin
      bus.ls_valid = 1'b1;
      bus.ls_addr  = addr;
      bus.ls_we    = we;
      bus.ls_size  = size;
      bus.ls_wdata = wdata;
      bus.flush    = fl;
    end
    bus.io_buffer_full = (stalls > 0);
    @(posedge clk);
    #1;
    t0    = cyc;
    e.cyc = t0 + lat;
    sb.push_back(e);
    bus.if_valid = 1'b0;
    bus.ls_valid = 1'b0;
    if (stalls > 0) begin
      repeat (stalls) @(posedge clk);
      #1 bus.io_buffer_full = 1'b0;
    end
    if (rgap > 0) begin
      repeat (2) @(posedge clk);
      #1 rdy = 1'b0;
      repeat (rgap) @(posedge clk);
      #1 rdy = 1'b1;
    end
    wait_done();
    bus.flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_if_ready"}, 128'(bus.if_ready), '0);
    check({tag, "_ls_ready"}, 128'(bus.ls_ready), '0);
    check({tag, "_mem_wr"},   128'(bus.mem_wr), '0);
    check({tag, "_mem_a"},    128'(bus.mem_a), '0);
    check({tag, "_mem_dout"}, 128'(bus.mem_dout), '0);
    check({tag, "_if_line"},  bus.if_line, '0);
    check({tag, "_ls_rdata"}, 128'(bus.ls_rdata), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          r_if, r_we, r_fl;
    logic [31:0] r_a, r_wd;
    logic [1:0]  r_sz;
    int          r_st;
    exp_t        e;

    bus.if_valid = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
    bus.ls_valid = 1'b0; bus.ls_addr = '0; bus.ls_we = 1'b0;
    bus.ls_size = '0; bus.ls_wdata = '0; bus.io_buffer_full = 1'b0;
    for (int i = 0; i < 262144; i++) ref_mem[i] = 8'(i);
    ref_mem[32'h20] = 8'h11; ref_mem[32'h21] = 8'h22;
    ref_mem[32'h22] = 8'h33; ref_mem[32'h23] = 8'h44;

    repeat (3) @(posedge clk);
    #1 load_mem = 1'b0;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Line refill from an unaligned address
    do_req(1'b1, 32'h1004, 1'b0, 2'd0, '0, 0, 0, 1'b0);
    // Word load, half store, half readback
    do_req(1'b0, 32'h20, 1'b0, 2'd2, '0, 0, 0, 1'b0);
    do_req(1'b0, 32'h40, 1'b1, 2'd1, 32'h0000BEEF, 0, 0, 1'b0);
    do_req(1'b0, 32'h40, 1'b0, 2'd1, '0, 0, 0, 1'b0);

    // Contention: ties alternate starting with the fetcher
    e.cyc = -1; e.chk = 1'b1;
    e.is_ls = 1'b0; e.data = model_read(32'h2000, LB); sb.push_back(e);
    e.is_ls = 1'b1; e.data = model_read(32'h2100, 4);  sb.push_back(e);
    e.is_ls = 1'b0; e.data = model_read(32'h2000, LB); sb.push_back(e);
    e.is_ls = 1'b1; e.data = model_read(32'h2100, 4);  sb.push_back(e);
    bus.ls_addr = 32'h2100; bus.ls_we = 1'b0; bus.ls_size = 2'd2;
    fork
      begin
        for (int r = 0; r < 2; r++) begin
          bit seen;
          seen = 1'b0;
          bus.if_addr = 32'h2000; bus.if_valid = 1'b1;
          for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = bus.if_ready; end
          if (!seen) begin n_cmp++; n_bad++; $display("FAIL contention_if_timeout: no if_ready, required one"); end
          bus.if_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      begin
        for (int r = 0; r < 2; r++) begin
          bit seen;
          seen = 1'b0;
          bus.ls_valid = 1'b1;
          for (int i = 0; i < 400 && !seen; i++) begin @(negedge clk); seen = bus.ls_ready; end
          if (!seen) begin n_cmp++; n_bad++; $display("FAIL contention_ls_timeout: no ls_ready, required one"); end
          bus.ls_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
    join
    check("contention_drained", 128'(sb.size()), '0);
    sb.delete();

    // Flush mid-refill drops it; the arbiter is idle on the next cycle
    bus.if_valid = 1'b1; bus.if_addr = 32'h3008;
    @(posedge clk); #1 bus.if_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    do_req(1'b1, 32'h3008, 1'b0, 2'd0, '0, 0, 0, 1'b0);
    // if_valid under flush in IDLE is not granted
    bus.if_valid = 1'b1; bus.if_addr = 32'h3100; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    do_req(1'b1, 32'h3100, 1'b0, 2'd0, '0, 0, 0, 1'b0);

    // I/O stall, then a full buffer that must not stall a non-I/O store
    do_req(1'b0, 32'h30000, 1'b1, 2'd0, 32'h41, 3, 0, 1'b0);
    do_req(1'b0, 32'h600, 1'b1, 2'd2, 32'hCAFEF00D, 2, 0, 1'b0);
    do_req(1'b0, 32'h600, 1'b0, 2'd3, '0, 0, 0, 1'b0);

    // rdy low mid-load and mid-refill
    do_req(1'b0, 32'h20, 1'b0, 2'd2, '0, 0, 4, 1'b0);
    do_req(1'b1, 32'h1000, 1'b0, 2'd0, '0, 0, 3, 1'b0);

    // Reset in the middle of a word store: only the first two bytes land
    model_store(32'h500, 2, 32'hA1B2C3D4);
    bus.ls_valid = 1'b1; bus.ls_addr = 32'h500; bus.ls_we = 1'b1;
    bus.ls_size = 2'd2; bus.ls_wdata = 32'hA1B2C3D4;
    @(posedge clk); #1 bus.ls_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b1;
    @(posedge clk); #1;
    do_req(1'b0, 32'h500, 1'b0, 2'd2, '0, 0, 0, 1'b0);

    // Randomised sequential traffic
    for (int t = 0; t < 60; t++) begin
      r_if = ($urandom % 4) == 0;
      r_a  = ($urandom % 2) ? 32'h800 + $urandom_range(0, 31) : $urandom_range(0, 32'h3FFE0);
      if (!r_if && ($urandom % 3) == 0) r_a = {14'b0, 2'b11, r_a[15:0] & 16'hFFF0};
      r_we = $urandom % 2;
      r_sz = 2'($urandom % 4);
      r_wd = $urandom;
      r_st = int'($urandom % 4);
      r_fl = !r_if && (($urandom % 3) == 0);
      do_req(r_if, r_a, r_if ? 1'b0 : r_we, r_sz, r_wd, r_if ? 0 : r_st, 0, r_fl);
    end

    repeat (3) @(posedge clk);
    #1;
    check("writes_drained", 128'(wq.size()), '0);
    check("responses_drained", 128'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
